// File: rtl/viterbi_branch_metric_pkg.sv
// Shared definitions for the Viterbi branch metric unit.
// Holds frame geometry, the per-edge expected codewords, the FSM state type and
// helpers that map trellis edges to stages and metric lanes.
// Optional feature macro: VITERBI_SOFT_EN (3-bit soft symbols, SYM_W = 6).
package viterbi_pkg;

    localparam int unsigned NUM_STAGES = 4;
    localparam int unsigned NUM_EDGES  = 24;
    localparam int unsigned MAX_LANES  = 8;   // edges in the widest stage
    localparam int unsigned BM_W       = 8;
    localparam int unsigned FCNT_W     = 8;

`ifdef VITERBI_SOFT_EN
    localparam int unsigned SYM_W = 6;
`else
    localparam int unsigned SYM_W = 2;
`endif

    // First edge index (0-based) and edge count of each stage.
    localparam int unsigned STAGE_OFS   [NUM_STAGES] = '{0, 4, 12, 20};
    localparam int unsigned STAGE_EDGES [NUM_STAGES] = '{4, 8, 8, 4};

    // Expected codeword per edge, stored as {c1, c0}; entry 0 is edge 1.
    localparam logic [1:0] EXP_CW [NUM_EDGES] = '{
        2'b00, 2'b11, 2'b01, 2'b10,
        2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10,
        2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10,
        2'b00, 2'b11, 2'b01, 2'b10
    };

    typedef enum logic {StCollect, StPresent} bm_state_e;

    function automatic int unsigned edge_stage(input int unsigned e);
        int unsigned st;
        st = 0;
        for (int unsigned s = 0; s < NUM_STAGES; s++) begin
            if (e >= STAGE_OFS[s]) st = s;
        end
        return st;
    endfunction

    function automatic int unsigned edge_lane(input int unsigned e);
        return e - STAGE_OFS[edge_stage(e)];
    endfunction

    // Codeword fed to a metric lane for the given stage; idle lanes see 00.
    function automatic logic [1:0] lane_codeword(input logic [1:0] stg, input int unsigned lane);
        if (lane >= STAGE_EDGES[stg]) return 2'b00;
        return EXP_CW[STAGE_OFS[stg] + lane];
    endfunction

endpackage

// File: rtl/viterbi_branch_metric_if.sv
// Symbol-in / frame-out handshake bundle of the branch metric unit.
// master: symbol source and ACS side (drives sym_in, sym_valid, bm_ready).
// slave : branch metric unit (drives sym_ready, bm, bm_valid, frame_cnt).
interface viterbi_branch_metric_if;
    import viterbi_pkg::*;

    logic [SYM_W-1:0]          sym_in;
    logic                      sym_valid;
    logic                      sym_ready;
    logic [NUM_EDGES*BM_W-1:0] bm;
    logic                      bm_valid;
    logic                      bm_ready;
    logic [FCNT_W-1:0]         frame_cnt;

    modport master (
        output sym_in, sym_valid, bm_ready,
        input  sym_ready, bm, bm_valid, frame_cnt
    );

    modport slave (
        input  sym_in, sym_valid, bm_ready,
        output sym_ready, bm, bm_valid, frame_cnt
    );

endinterface

// File: rtl/viterbi_bm_calc.sv
// Combinational distance of one received symbol to one expected codeword.
// Ports: sym (received symbol), cw ({c1, c0} expected), metric (zero-extended).
// Hard build: Hamming distance 0..2. VITERBI_SOFT_EN: sum of 3-bit confidence
// distances 0..14, where q counts toward an expected 0 and 7-q toward a 1.
module viterbi_bm_calc
    import viterbi_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    input  logic [1:0]       cw,
    output logic [BM_W-1:0]  metric
);

`ifdef VITERBI_SOFT_EN
    logic [3:0] d0;
    logic [3:0] d1;

    always_comb begin
        d0     = cw[0] ? {1'b0, 3'd7 - sym[2:0]} : {1'b0, sym[2:0]};
        d1     = cw[1] ? {1'b0, 3'd7 - sym[5:3]} : {1'b0, sym[5:3]};
        metric = BM_W'(d0 + d1);
    end
`else
    always_comb begin
        metric = BM_W'({1'b0, sym[0] ^ cw[0]} + {1'b0, sym[1] ^ cw[1]});
    end
`endif

endmodule

// File: rtl/viterbi_branch_metric.sv
// Branch metric unit feeding the 4-stage ACS trellis.
// Accepts one symbol per trellis stage, registers that stage's edge metrics and
// presents the full 24-edge frame once all four stages are in.
// Ports: clk, rst_n (async, active-low), bus (slave side of the handshake bundle:
// sym_in/sym_valid/sym_ready in, bm/bm_valid/bm_ready out, frame_cnt).
// Optional feature macro: VITERBI_SOFT_EN (soft-decision metrics).
module viterbi_branch_metric
    import viterbi_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    viterbi_branch_metric_if.slave  bus
);

    bm_state_e         state_q, state_d;
    logic [1:0]        stg_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic              sym_ready_s;
    logic              bm_valid_s;
    logic              sym_acc;
    logic              bm_acc;
    logic [1:0]        lane_cw [MAX_LANES];
    logic [BM_W-1:0]   lane_bm [MAX_LANES];

    assign sym_acc = bus.sym_valid && sym_ready_s;
    assign bm_acc  = bm_valid_s && bus.bm_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StCollect;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCollect: if (sym_acc && stg_q == 2'd3) state_d = StPresent;
            StPresent: if (bm_acc) state_d = StCollect;
            default:   state_d = StCollect;
        endcase
    end

    // Outputs decode the state flop, so bm_valid is registered.
    always_comb begin
        sym_ready_s = (state_q == StCollect);
        bm_valid_s  = (state_q == StPresent);
    end

    // Stage counter wraps 3 -> 0 on the last accept of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_q       <= 2'd0;
            frame_cnt_q <= '0;
        end else begin
            if (sym_acc) stg_q <= stg_q + 2'd1;
            if (bm_acc)  frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    // Eight shared metric lanes; narrow stages leave the upper lanes unused.
    for (genvar i = 0; i < MAX_LANES; i++) begin : g_lane
        assign lane_cw[i] = lane_codeword(stg_q, i);

        viterbi_bm_calc u_calc (
            .sym    (bus.sym_in),
            .cw     (lane_cw[i]),
            .metric (lane_bm[i])
        );
    end

    // Each edge register loads only when its own stage's symbol is accepted.
    for (genvar e = 0; e < NUM_EDGES; e++) begin : g_edge
        localparam int unsigned EStg  = edge_stage(e);
        localparam int unsigned ELane = edge_lane(e);

        logic [BM_W-1:0] bm_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                           bm_q <= '0;
            else if (sym_acc && stg_q == 2'(EStg)) bm_q <= lane_bm[ELane];
        end

        assign bus.bm[BM_W*e +: BM_W] = bm_q;
    end

    assign bus.sym_ready = sym_ready_s;
    assign bus.bm_valid  = bm_valid_s;
    assign bus.frame_cnt = frame_cnt_q;

endmodule
